bk_adder_arbiter: RTL and testbench

//  Shares one combinational 12-bit BrentKung adder core (24 in, 13 out) between NUM_REQ requesters.
//  - Round-robin arbitration over valid/ready request ports.
//  - Operand register stage feeds the shared adder; a result register drives a valid/ready response port.
//  - The response carries the requester ID.
//  - Sits between the agents that issue 12-bit adds and the single adder instance.

---
 rtl/bk_arb_pkg.sv | 38 +++
 rtl/bk_adder_core.sv | 42 ++++
 rtl/bk_rr_arbiter.sv | 42 ++++
 rtl/bk_adder_arbiter.sv | 115 +++++++++++
 tb/tb_bk_adder_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bk_arb_pkg.sv
// Shared types, widths and the round-robin pick function for the shared
// Brent-Kung adder arbiter.
package bk_arb_pkg;

    localparam int OP_W     = 12;
    localparam int SUM_W    = 13;
    localparam int MAX_REQ  = 8;
    localparam int MAX_ID_W = 3;

    typedef struct packed {
        logic [OP_W-1:0]     a;
        logic [OP_W-1:0]     b;
        logic [MAX_ID_W-1:0] id;
    } op_t;

    // One-hot grant to the first valid requester at or after ptr, wrapping at n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0]  valid,
                                                   input logic [MAX_ID_W-1:0] ptr,
                                                   input int                  n);
        logic [MAX_REQ-1:0]  grant;
        logic                found;
        logic [MAX_ID_W:0]   pos;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                pos = {1'b0, ptr} + (MAX_ID_W+1)'(k);
                if (pos >= (MAX_ID_W+1)'(n)) pos = pos - (MAX_ID_W+1)'(n);
                if (!found && valid[pos[MAX_ID_W-1:0]]) begin
                    grant[pos[MAX_ID_W-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/bk_adder_core.sv
// Combinational 12-bit Brent-Kung adder; operand bits arrive interleaved
// (a[k] at 2k, b[k] at 2k+1), sum bit 12 is the carry-out.
module bk_adder_core
    import bk_arb_pkg::*;
(
    input  logic [2*OP_W-1:0] core_in,
    output logic [SUM_W-1:0]  core_sum
);

    localparam int TOP = 1 << ($clog2(OP_W + 1) - 1);

    logic [OP_W-1:0] hs;
    logic [OP_W-1:0] g;
    logic [OP_W-1:0] p;

    // NOTE: every combinational output gets a default before any conditional
    // update so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < OP_W; k++) begin
            g[k]  = core_in[2*k] & core_in[2*k+1];
            hs[k] = core_in[2*k] ^ core_in[2*k+1];
        end
        p = hs;
        // Up-sweep builds prefixes at 2^j-1, down-sweep fills the gaps.
        for (int d = 1; d < OP_W; d = d * 2) begin
            for (int i = 2*d - 1; i < OP_W; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        for (int d = TOP / 2; d >= 1; d = d / 2) begin
            for (int i = 3*d - 1; i < OP_W; i = i + 2*d) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        core_sum[0] = hs[0];
        for (int k = 1; k < OP_W; k++) core_sum[k] = hs[k] ^ g[k-1];
        core_sum[OP_W] = g[OP_W-1];
    end

endmodule

// File: rtl/bk_rr_arbiter.sv
// Round-robin picker with its pointer; the pointer moves past the winner
// only when the caller reports that the grant was taken.
module bk_rr_arbiter
    import bk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    always_comb begin
        pick     = rr_pick(MAX_REQ'(req_valid), MAX_ID_W'(ptr_q), NUM_REQ);
        grant    = pick[NUM_REQ-1:0];
        grant_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick[i]) grant_id = ID_W'(i);
        end
        ptr_d = ptr_q;
        if (advance) ptr_d = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    end

    assign unused_pick = ^pick;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/bk_adder_arbiter.sv
// Shares one Brent-Kung adder among NUM_REQ requesters: round-robin grant,
// operand stage S1, adder, result stage S2 with a valid/ready response.
module bk_adder_arbiter
    import bk_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    output logic [SUM_W-1:0]        rsp_sum,
    output logic [ID_W-1:0]         rsp_id,
    input  logic                    rsp_ready,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    op_t               s1_q, s1_d, sel;
    logic              v1_q, v1_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               s2_free, s1_adv, s1_free, accept;
    logic [2*OP_W-1:0]  core_in;
    logic [SUM_W-1:0]   core_sum;
    logic               unused_id;

    bk_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_id  (grant_id)
    );

    bk_adder_core u_core (
        .core_in  (core_in),
        .core_sum (core_sum)
    );

    // Handshake: S1 may take a new op whenever its current op moves on this cycle.
    always_comb begin
        s2_free   = ~rsp_valid_q | rsp_ready;
        s1_adv    = v1_q & s2_free;
        s1_free   = ~v1_q | s1_adv;
        req_ready = (enable && s1_free && !rst) ? grant : '0;
        accept    = |(req_valid & req_ready);
    end

    always_comb begin
        sel    = '0;
        sel.id = MAX_ID_W'(grant_id);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel.a = req_a[OP_W*i +: OP_W];
                sel.b = req_b[OP_W*i +: OP_W];
            end
        end
        s1_d = accept ? sel : s1_q;
        v1_d = accept | (v1_q & ~s1_adv);

        for (int k = 0; k < OP_W; k++) begin
            core_in[2*k]   = s1_q.a[k];
            core_in[2*k+1] = s1_q.b[k];
        end

        rsp_valid_d = s1_adv | (rsp_valid_q & ~rsp_ready);
        sum_d       = s1_adv ? core_sum : sum_q;
        id_d        = s1_adv ? ID_W'(s1_q.id) : id_q;

        cnt_d = cnt_q;
        if (rsp_valid_q && rsp_ready && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
    end

    assign unused_id = ^s1_q.id;

    // NOTE: the operand payload is reset along with its valid bit; it is only
    // a few flops and keeps rsp_sum/rsp_id at zero after reset without special cases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            s1_q        <= '0;
            rsp_valid_q <= 1'b0;
            sum_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            s1_q        <= s1_d;
            rsp_valid_q <= rsp_valid_d;
            sum_q       <= sum_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = sum_q;
    assign rsp_id    = id_q;
    assign busy      = v1_q | rsp_valid_q;
    assign ops_done  = cnt_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Randomized bench: an acceptor process predicts grants and queues expected
// sums; a separate monitor pops and compares every consumed response.
module tb_bk_adder_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ*12-1:0] req_a;
    logic [NUM_REQ*12-1:0] req_b;
    logic [NUM_REQ-1:0]  req_ready;
    logic                rsp_valid;
    logic [12:0]         rsp_sum;
    logic [ID_W-1:0]     rsp_id;
    logic                rsp_ready;
    logic                busy;
    logic [CNT_W-1:0]    ops_done;

    always #5 clk = ~clk;

    bk_adder_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    typedef struct {
        logic [12:0]     sum;
        logic [ID_W-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   ptr_m = 0;

    // Reference arbitration: first valid requester scanning upward from ptr.
    function automatic int model_pick(input logic [NUM_REQ-1:0] v, input int p);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (v[(p + k) % NUM_REQ]) return (p + k) % NUM_REQ;
        end
        return -1;
    endfunction

    // Acceptor: predicts the grant and queues the expected response.
    int          acc_win;
    logic [11:0] acc_a, acc_b;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            ptr_m = 0;
        end else begin
            check("busy", 32'(busy), 32'(exp_q.size() != 0));
            check("grant_subset", 32'(req_ready & ~req_valid), 0);
            if (!enable) check("grant_disabled", 32'(req_ready), 0);
            if (enable && rsp_ready && req_valid != 0)
                check("throughput_grant", 32'(req_ready != 0), 1);
            if (req_ready != 0) begin
                acc_win = model_pick(req_valid, ptr_m);
                if (acc_win < 0) begin
                    check("rr_winner", 32'(req_ready), 0);
                end else begin
                    check("rr_winner", 32'(req_ready), 32'(1 << acc_win));
                    acc_a = req_a[12*acc_win +: 12];
                    acc_b = req_b[12*acc_win +: 12];
                    exp_q.push_back('{sum: {1'b0, acc_a} + {1'b0, acc_b}, id: ID_W'(acc_win)});
                    ptr_m = (acc_win + 1) % NUM_REQ;
                end
            end
        end
    end

    // Monitor: compares consumed responses, held outputs and the counter.
    int              ops_m = 0;
    logic            hold_v = 1'b0;
    logic [12:0]     hold_sum;
    logic [ID_W-1:0] hold_id;
    exp_t            mon_e;
    always begin
        @(negedge clk);
        #1;
        if (rst) begin
            ops_m  = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                check("hold_sum", 32'(rsp_sum), 32'(hold_sum));
                check("hold_id", 32'(rsp_id), 32'(hold_id));
            end
            check("ops_done", 32'(ops_done), 32'(ops_m));
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("rsp_sum", 32'(rsp_sum), 32'(mon_e.sum));
                    check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
                end
                if (ops_m < (1 << CNT_W) - 1) ops_m++;
            end
            hold_v   = rsp_valid && !rsp_ready;
            hold_sum = rsp_sum;
            hold_id  = rsp_id;
        end
    end

    int n_stim_acc = 0;

    task automatic new_operand(input int i);
        req_a[12*i +: 12] = 12'($urandom);
        req_b[12*i +: 12] = 12'($urandom);
    endtask

    // One clock: note which requests the DUT is taking, then refresh their operands.
    task automatic step();
        logic [NUM_REQ-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc[i]) begin
                new_operand(i);
                n_stim_acc++;
            end
        end
    endtask

    task automatic drain(input string name);
        int guard;
        req_valid = '0;
        rsp_ready = 1'b1;
        guard = 0;
        while (busy && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_idle"}, 32'(busy), 0);
        @(negedge clk);
        #2;
        check({name, "_queue_empty"}, 32'(exp_q.size()), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int start_acc;

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_sum", 32'(rsp_sum), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_ops_done", 32'(ops_done), 0);
        check("rst_busy", 32'(busy), 0);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;

        // Single op with carry into bit 12.
        @(posedge clk);
        #1;
        req_a[11:0] = 12'hFFF;
        req_b[11:0] = 12'h001;
        req_valid   = 4'b0001;
        @(negedge clk);
        check("t1_ready", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        req_valid = '0;
        check("t1_no_early_rsp", 32'(rsp_valid), 0);
        @(posedge clk);
        #1;
        check("t1_rsp_valid", 32'(rsp_valid), 1);
        check("t1_sum", 32'(rsp_sum), 32'h1000);
        check("t1_id", 32'(rsp_id), 0);
        @(posedge clk);
        #1;
        check("t1_ops_done", 32'(ops_done), 1);
        check("t1_rsp_drop", 32'(rsp_valid), 0);

        // Streaming with all requesters valid.
        for (int i = 0; i < NUM_REQ; i++) new_operand(i);
        req_valid = '1;
        for (int s = 0; s < 24; s++) begin
            step();
            if (s >= 1) check("t2_stream", 32'(rsp_valid), 1);
        end
        drain("t2");

        // Backpressure with three requesters.
        rsp_ready = 1'b0;
        req_valid = 4'b0111;
        start_acc = n_stim_acc;
        repeat (5) step();
        check("t3_accepts", 32'(n_stim_acc - start_acc), 2);
        @(negedge clk);
        check("t3_blocked", 32'(req_ready), 0);
        @(posedge clk);
        #1;
        drain("t3");

        // Reset with both stages full.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (2) step();
        check("t4_full_busy", 32'(busy), 1);
        check("t4_full_rsp", 32'(rsp_valid), 1);
        #2;
        rst = 1'b1;
        #1;
        check("t4_async_rsp", 32'(rsp_valid), 0);
        check("t4_async_busy", 32'(busy), 0);
        check("t4_async_ready", 32'(req_ready), 0);
        check("t4_async_cnt", 32'(ops_done), 0);
        req_valid = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(posedge clk);
            #1;
            check("t4_no_stale", 32'(rsp_valid), 0);
        end
        req_valid = '1;
        @(negedge clk);
        check("t4_ptr_zero", 32'(req_ready), 32'b0001);
        @(posedge clk);
        #1;
        new_operand(0);
        repeat (3) step();
        drain("t4");

        // Enable low with requests pending and ops in flight.
        req_valid = '1;
        repeat (2) step();
        enable    = 1'b0;
        start_acc = n_stim_acc;
        repeat (5) step();
        check("t5_no_grants", 32'(n_stim_acc - start_acc), 0);
        check("t5_drained", 32'(busy), 0);
        enable = 1'b1;
        @(negedge clk);
        check("t5_resume", 32'(req_ready), 32'(1 << ptr_m));
        @(posedge clk);
        #1;
        drain("t5");

        // Random traffic until the 4-bit counter saturates.
        start_acc = n_stim_acc;
        for (int s = 0; s < 400 && (n_stim_acc - start_acc) < 20; s++) begin
            req_valid = NUM_REQ'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        check("t6_enough_ops", 32'((n_stim_acc - start_acc) >= 20), 1);
        drain("t6");
        check("t6_saturated", 32'(ops_done), 32'hF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
